// File: rtl/gelato_types_pkg.sv
// Shared widths, types and helpers for the warp register scoreboard.
// Optional feature macro: GELATO_SCOREBOARD_BYPASS_EN (same-cycle writeback bypass).
package gelato_types;

  localparam int WARP_NUM = 4;
  localparam int SLOTS    = 8;
  localparam int REG_W    = 5;
  localparam int SRC_NUM  = 3;
  localparam int WB_PORTS = 2;

  localparam int WW     = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNT_W  = $clog2(SLOTS) + 1;

  typedef logic [REG_W-1:0] reg_num_t;
  typedef logic [WW-1:0]    warp_num_t;

  // One tracked destination: register index is meaningful only while valid is set.
  typedef struct packed {
    logic     valid;
    reg_num_t regnum;
  } sb_entry_t;

  // Population count of a slot valid vector; result spans 0..SLOTS without wrap.
  function automatic logic [CNT_W-1:0] count_valid(input logic [SLOTS-1:0] vec);
    logic [CNT_W-1:0] total;
    total = '0;
    for (int i = 0; i < SLOTS; i++) begin
      total = total + CNT_W'(vec[i]);
    end
    return total;
  endfunction

endpackage

// File: rtl/gelato_scoreboard_warp.sv
// Slot array for a single warp: hazard lookups, lowest-free allocation,
// multi-port release matching and an occupancy count.
// Optional feature macro: GELATO_SCOREBOARD_BYPASS_EN hides slots being
// released this cycle from lookups and from the free-slot search.
module gelato_scoreboard_warp
  import gelato_types::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [(SRC_NUM+1)*REG_W-1:0]   lookup_reg,
  output logic [SRC_NUM:0]               lookup_match,
  input  logic [WB_PORTS-1:0]            rel_valid,
  input  logic [WB_PORTS*REG_W-1:0]      rel_rd,
  input  logic                           alloc_en,
  input  reg_num_t                       alloc_rd,
  output logic                           free_avail,
  output logic                           full,
  output logic [CNT_W-1:0]               occupancy,
  output logic                           rel_err
);

  sb_entry_t            slots_q [SLOTS];
  logic [SLOTS-1:0]     valid_vec;
  logic [SLOTS-1:0]     clear_mask;
  logic [SLOTS-1:0]     view_vec;
  logic [SLOTS-1:0]     avail_vec;
  logic [SLOTS-1:0]     alloc_onehot;
  logic [SLOTS-1:0]     valid_next;
  logic [WB_PORTS-1:0]  rel_hit;
  logic [WB_PORTS-1:0]  rel_dup;

  // Flatten slot valid bits for vector arithmetic.
  always_comb begin
    valid_vec = '0;
    for (int s = 0; s < SLOTS; s++) begin
      valid_vec[s] = slots_q[s].valid;
    end
  end

  // Match each release port against the slots; a miss or a repeated register across ports is an error.
  always_comb begin
    clear_mask = '0;
    rel_hit    = '0;
    rel_dup    = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (rel_valid[p] && slots_q[s].valid &&
            (slots_q[s].regnum == rel_rd[p*REG_W +: REG_W])) begin
          clear_mask[s] = 1'b1;
          rel_hit[p]    = 1'b1;
        end
      end
      for (int q = 0; q < p; q++) begin
        if (rel_valid[p] && rel_valid[q] &&
            (rel_rd[p*REG_W +: REG_W] == rel_rd[q*REG_W +: REG_W])) begin
          rel_dup[p] = 1'b1;
        end
      end
    end
    rel_err = |(rel_valid & (~rel_hit | rel_dup));
  end

`ifdef GELATO_SCOREBOARD_BYPASS_EN
  assign view_vec = valid_vec & ~clear_mask;
`else
  assign view_vec = valid_vec;
`endif

  assign avail_vec  = ~view_vec;
  assign free_avail = |avail_vec;
  assign full       = &valid_vec;

  // Compare every source plus the destination against the visible slots; register 0 never matches.
  always_comb begin
    lookup_match = '0;
    for (int k = 0; k <= SRC_NUM; k++) begin
      if (lookup_reg[k*REG_W +: REG_W] != '0) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (view_vec[s] && (slots_q[s].regnum == lookup_reg[k*REG_W +: REG_W])) begin
            lookup_match[k] = 1'b1;
          end
        end
      end
    end
  end

  // Pick the lowest available slot index for a new allocation.
  always_comb begin
    logic found;
    found        = 1'b0;
    alloc_onehot = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (alloc_en && avail_vec[s] && !found) begin
        alloc_onehot[s] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  assign valid_next = (valid_vec & ~clear_mask) | alloc_onehot;

  // Commit releases and allocation together; occupancy follows the new valid set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SLOTS; s++) begin
        slots_q[s] <= '0;
      end
      occupancy <= '0;
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        slots_q[s].valid <= valid_next[s];
        if (alloc_onehot[s]) begin
          slots_q[s].regnum <= alloc_rd;
        end
      end
      occupancy <= count_valid(valid_next);
    end
  end

endmodule

// File: rtl/gelato_warp_scoreboard.sv
// Per-warp register scoreboard between warp scheduler and operand collector.
// Gates issue on RAW/WAW hazards and slot exhaustion, retires entries from
// several writeback ports, reports occupancy and a sticky protocol error.
// Optional feature macro: GELATO_SCOREBOARD_BYPASS_EN (same-cycle writeback bypass).
module gelato_warp_scoreboard
  import gelato_types::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic                          issue_valid,
  input  warp_num_t                     issue_warp,
  input  logic [SRC_NUM*REG_W-1:0]      issue_rs,
  input  reg_num_t                      issue_rd,
  output logic                          issue_ready,
  output logic                          hazard,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*WW-1:0]        wb_warp,
  input  logic [WB_PORTS*REG_W-1:0]     wb_rd,
  output logic                          wb_ready,
  output logic [WARP_NUM*CNT_W-1:0]     occupancy,
  output logic [WARP_NUM-1:0]           warp_full,
  output logic                          sb_err
);

  logic [(SRC_NUM+1)*REG_W-1:0]         lookup_reg;
  logic [WARP_NUM-1:0][SRC_NUM:0]       warp_match;
  logic [WARP_NUM-1:0][WB_PORTS-1:0]    rel_valid;
  logic [WARP_NUM-1:0]                  warp_free;
  logic [WARP_NUM-1:0]                  warp_err;
  logic [WARP_NUM-1:0]                  alloc_en;
  logic [SRC_NUM:0]                     sel_match;
  logic                                 sel_free;
  logic                                 fire;

  // Destination sits above the sources so every warp checks RAW and WAW in one lookup.
  assign lookup_reg = {issue_rd, issue_rs};
  assign wb_ready   = rdy;

  // Select the issuing warp's lookup results and derive the issue handshake.
  always_comb begin
    sel_match   = warp_match[issue_warp];
    sel_free    = warp_free[issue_warp];
    hazard      = issue_valid & (|sel_match);
    issue_ready = rdy & ~hazard & ((issue_rd == '0) | sel_free);
    fire        = issue_valid & issue_ready;
  end

  // Route the allocation and the writeback releases to their owning warps; rdy low blocks both.
  always_comb begin
    alloc_en  = '0;
    rel_valid = '0;
    for (int w = 0; w < WARP_NUM; w++) begin
      alloc_en[w] = fire && (issue_rd != '0) && (issue_warp == warp_num_t'(w));
      for (int p = 0; p < WB_PORTS; p++) begin
        rel_valid[w][p] = rdy && wb_valid[p] && (wb_rd[p*REG_W +: REG_W] != '0) &&
                          (wb_warp[p*WW +: WW] == warp_num_t'(w));
      end
    end
  end

  for (genvar gw = 0; gw < WARP_NUM; gw++) begin : g_warp
    gelato_scoreboard_warp u_warp (
      .clk          (clk),
      .rst_n        (rst_n),
      .lookup_reg   (lookup_reg),
      .lookup_match (warp_match[gw]),
      .rel_valid    (rel_valid[gw]),
      .rel_rd       (wb_rd),
      .alloc_en     (alloc_en[gw]),
      .alloc_rd     (issue_rd),
      .free_avail   (warp_free[gw]),
      .full         (warp_full[gw]),
      .occupancy    (occupancy[gw*CNT_W +: CNT_W]),
      .rel_err      (warp_err[gw])
    );
  end

  // Protocol errors from any warp latch until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err <= 1'b0;
    end else begin
      sb_err <= sb_err | (|warp_err);
    end
  end

endmodule

// File: tb/tb_gelato_warp_scoreboard.sv
// Directed self-checking bench for gelato_warp_scoreboard.
// Expectations adapt to GELATO_SCOREBOARD_BYPASS_EN when it is defined.
module tb_gelato_warp_scoreboard;
  import gelato_types::*;

`ifdef GELATO_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       rdy;
  logic                       issue_valid;
  warp_num_t                  issue_warp;
  logic [SRC_NUM*REG_W-1:0]   issue_rs;
  reg_num_t                   issue_rd;
  logic                       issue_ready;
  logic                       hazard;
  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*WW-1:0]     wb_warp;
  logic [WB_PORTS*REG_W-1:0]  wb_rd;
  logic                       wb_ready;
  logic [WARP_NUM*CNT_W-1:0]  occupancy;
  logic [WARP_NUM-1:0]        warp_full;
  logic                       sb_err;

  int assert_count = 0;
  int fail_count   = 0;

  gelato_warp_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .issue_valid (issue_valid),
    .issue_warp  (issue_warp),
    .issue_rs    (issue_rs),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .hazard      (hazard),
    .wb_valid    (wb_valid),
    .wb_warp     (wb_warp),
    .wb_rd       (wb_rd),
    .wb_ready    (wb_ready),
    .occupancy   (occupancy),
    .warp_full   (warp_full),
    .sb_err      (sb_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [1:0] iw,
                               input logic [4:0] rs0, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [1:0] wbv,
                               input logic [1:0] ww0, input logic [4:0] wr0,
                               input logic [1:0] ww1, input logic [4:0] wr1);
    issue_valid = iv;
    issue_warp  = iw;
    issue_rs    = {rs2, rs1, rs0};
    issue_rd    = rd;
    wb_valid    = wbv;
    wb_warp     = {ww1, ww0};
    wb_rd       = {wr1, wr0};
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] occ_of(input int w);
    return 32'(occupancy[w*CNT_W +: CNT_W]);
  endfunction

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #2;
    checkOutput("reset_occ",   32'(occupancy), 32'h0);
    checkOutput("reset_full",  32'(warp_full), 32'h0);
    checkOutput("reset_err",   32'(sb_err), 32'h0);
    checkOutput("reset_ready", 32'(issue_ready), 32'h0);
    checkOutput("reset_haz",   32'(hazard), 32'h0);
    checkOutput("reset_wbrdy", 32'(wb_ready), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    rdy   = 1'b1;

    // Single allocate then RAW / WAW / other-warp lookups
    applyStimulus(1, 0, 0, 0, 0, 5, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t1_ready",  32'(issue_ready), 32'h1);
    checkOutput("t1_haz",    32'(hazard), 32'h0);
    checkOutput("t1_wbrdy",  32'(wb_ready), 32'h1);
    tick();
    checkOutput("t1_occ0",   occ_of(0), 32'd1);
    applyStimulus(1, 0, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t1_raw_haz",   32'(hazard), 32'h1);
    checkOutput("t1_raw_ready", 32'(issue_ready), 32'h0);
    applyStimulus(1, 1, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t1_w1_haz",    32'(hazard), 32'h0);
    checkOutput("t1_w1_ready",  32'(issue_ready), 32'h1);
    applyStimulus(1, 0, 0, 0, 7, 5, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t1_waw_haz",   32'(hazard), 32'h1);
    checkOutput("t1_waw_ready", 32'(issue_ready), 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t1_nodst_ready", 32'(issue_ready), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;

    // Fill warp 2
    for (int r = 1; r <= SLOTS; r++) begin
      applyStimulus(1, 2, 0, 0, 0, 5'(r), 2'b00, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(1, 2, 0, 0, 0, 9, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t2_occ2",     occ_of(2), 32'd8);
    checkOutput("t2_full",     32'(warp_full), 32'h4);
    checkOutput("t2_rd9_ready", 32'(issue_ready), 32'h0);
    checkOutput("t2_rd9_haz",  32'(hazard), 32'h0);
    applyStimulus(1, 2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t2_rd0_ready", 32'(issue_ready), 32'h1);

    // Release rd=3 in warp 2, then refill
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, 2, 3, 0, 0);
    tick();
    applyStimulus(1, 2, 0, 0, 0, 9, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t3_occ2",     occ_of(2), 32'd7);
    checkOutput("t3_full",     32'(warp_full), 32'h0);
    checkOutput("t3_ready",    32'(issue_ready), 32'h1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t3_occ2_refill", occ_of(2), 32'd8);
    checkOutput("t3_full_refill", 32'(warp_full), 32'h4);

    // Same-cycle writeback of the blocking register
    applyStimulus(1, 0, 5, 0, 0, 0, 2'b01, 0, 5, 0, 0);
    #1;
    checkOutput("t4_byp_ready", 32'(issue_ready), 32'(BYP));
    checkOutput("t4_byp_haz",   32'(hazard), 32'(!BYP));
    tick();
    applyStimulus(1, 0, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t4_next_ready", 32'(issue_ready), 32'h1);
    checkOutput("t4_next_haz",   32'(hazard), 32'h0);
    checkOutput("t4_occ0",       occ_of(0), 32'd0);
    // Full warp allocating while a slot is released
    applyStimulus(1, 2, 0, 0, 0, 10, 2'b01, 2, 4, 0, 0);
    #1;
    checkOutput("t4_full_ready", 32'(issue_ready), 32'(BYP));
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t4_full_occ2", occ_of(2), BYP ? 32'd8 : 32'd7);

    // Dual-port release of one register
    checkOutput("t5_err_clean", 32'(sb_err), 32'h0);
    applyStimulus(1, 3, 0, 0, 0, 12, 2'b00, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t5_occ3_alloc", occ_of(3), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b11, 3, 12, 3, 12);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t5_dual_occ3", occ_of(3), 32'd0);
    checkOutput("t5_dual_err",  32'(sb_err), 32'h1);

    // rdy low freezes everything
    rdy = 1'b0;
    applyStimulus(1, 1, 0, 0, 0, 20, 2'b01, 2, 1, 0, 0);
    #1;
    checkOutput("t6_frz_ready", 32'(issue_ready), 32'h0);
    checkOutput("t6_frz_wbrdy", 32'(wb_ready), 32'h0);
    tick();
    rdy = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t6_frz_occ1", occ_of(1), 32'd0);
    checkOutput("t6_frz_occ2", occ_of(2), BYP ? 32'd8 : 32'd7);
    checkOutput("t6_frz_err",  32'(sb_err), 32'h1);
    applyStimulus(1, 1, 0, 0, 0, 20, 2'b00, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t6_occ1", occ_of(1), 32'd1);

    // Asynchronous reset in the middle of the low phase
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_arst_occ",  32'(occupancy), 32'h0);
    checkOutput("t6_arst_full", 32'(warp_full), 32'h0);
    checkOutput("t6_arst_err",  32'(sb_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Writebacks arriving after reset find nothing pending
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, 1, 20, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("t5_miss_err", 32'(sb_err), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, 1, 7, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("t5_err_held",  32'(sb_err), 32'h1);
    checkOutput("t5_occ_final", 32'(occupancy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
